uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 113 +++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with oversampled mid-bit sampling.
// Divider and sample counter realign to each start edge.
module uart_rx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int OVERSAMPLING = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLING);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLING) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [SW-1:0] HALF = SW'(OVERSAMPLING / 2 - 1);
    localparam logic [SW-1:0] FULL = SW'(OVERSAMPLING - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t state, state_n;
    logic rx_q, rx_s, rx_d;
    logic [DW-1:0] div, div_n;
    logic [SW-1:0] sc, sc_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] shreg, sh_n, data_n;
    logic dv_n, fe_n, tick;

    assign tick = (state != IDLE) && (div == DIV_LAST);

    always_comb begin
        state_n = state;
        div_n   = (state == IDLE || tick) ? '0 : div + 1'b1;
        sc_n    = tick ? sc + 1'b1 : sc;
        bit_n   = bit_idx;
        sh_n    = shreg;
        data_n  = data_out;
        dv_n    = 1'b0;
        fe_n    = 1'b0;
        case (state)
            IDLE: begin
                sc_n = '0;
                if (rx_d && !rx_s)
                    state_n = START;
            end
            START: begin
                if (tick && sc == HALF) begin
                    sc_n    = '0;
                    bit_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && sc == FULL) begin
                    sc_n  = '0;
                    sh_n  = {rx_s, shreg[7:1]};
                    bit_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                end
            end
            STOP: begin
                if (tick && sc == FULL) begin
                    sc_n    = '0;
                    data_n  = rx_s ? shreg : data_out;
                    dv_n    = rx_s;
                    fe_n    = !rx_s;
                    state_n = rx_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                sc_n = '0;
                if (rx_s)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rx_q       <= 1'b1;
            rx_s       <= 1'b1;
            rx_d       <= 1'b1;
            div        <= '0;
            sc         <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            rx_q       <= rx;
            rx_s       <= rx_q;
            rx_d       <= rx_s;
            div        <= div_n;
            sc         <= sc_n;
            bit_idx    <= bit_n;
            shreg      <= sh_n;
            data_out   <= data_n;
            data_valid <= dv_n;
            frame_err  <= fe_n;
            busy       <= state_n != IDLE;
        end
    end
endmodule
